// File: rtl/leaf_out_arbiter.sv
// leaf_out_arbiter: round-robin merge of the user output streams onto the single leaf-to-BFT
// packet port, gated by per-port freespace credits and stamped with destination and BRAM address.
//
// state    | meaning
// ST_IDLE  | no grants; waiting for start
// ST_RUN   | arbitrating user streams into the packet register
// ST_DRAIN | stop seen; waiting for the last packet to leave
module leaf_out_arbiter #(
  parameter int NUM_OUT_PORTS         = 3,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64,
  parameter int PACKET_BITS           = 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS,
  parameter int SEL_BITS              = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic                                  stop,
  output logic                                  busy,
  input  logic                                  cfg_wr_en,
  input  logic [SEL_BITS-1:0]                   cfg_sel,
  input  logic [NUM_LEAF_BITS-1:0]              cfg_leaf,
  input  logic [NUM_PORT_BITS-1:0]              cfg_dport,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_user,
  input  logic [NUM_OUT_PORTS-1:0]              vld_user,
  output logic [NUM_OUT_PORTS-1:0]              ack_user,
  input  logic [NUM_OUT_PORTS-1:0]              credit_upd,
  output logic [PACKET_BITS-1:0]                pkt_out,
  output logic                                  pkt_vld,
  input  logic                                  pkt_ack
);

  localparam int CRED_BITS = NUM_ADDR_BITS + 1;
  localparam int DEPTH     = 2 ** NUM_ADDR_BITS;
  localparam logic [CRED_BITS-1:0] CRED_MAX   = CRED_BITS'(DEPTH);
  localparam logic [CRED_BITS:0]   CRED_MAX_X = {1'b0, CRED_MAX};
  localparam logic [CRED_BITS:0]   CRED_UPD   = (CRED_BITS + 1)'(FREESPACE_UPDATE_SIZE);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  state_t                     state_q, state_d;
  logic [SEL_BITS-1:0]        ptr_q, ptr_d;
  logic [NUM_OUT_PORTS-1:0]   entry_valid_q;
  logic [NUM_LEAF_BITS-1:0]   leaf_q   [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0]   dport_q  [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0]   addr_q   [NUM_OUT_PORTS];
  logic [CRED_BITS-1:0]       credit_q [NUM_OUT_PORTS];
  logic [CRED_BITS-1:0]       credit_d [NUM_OUT_PORTS];
  logic [CRED_BITS:0]         cred_sum [NUM_OUT_PORTS];

  logic                       slot_free, grant_en, found;
  logic [SEL_BITS-1:0]        gidx;
  logic [NUM_OUT_PORTS-1:0]   eligible, grant;
  logic [PAYLOAD_BITS-1:0]    sel_payload;
  logic [NUM_LEAF_BITS-1:0]   sel_leaf;
  logic [NUM_PORT_BITS-1:0]   sel_dport;
  logic [NUM_ADDR_BITS-1:0]   sel_addr;

  assign slot_free = !pkt_vld || pkt_ack;
  assign grant_en  = (state_q == ST_RUN) && slot_free;
  assign busy      = (state_q != ST_IDLE);
  assign ack_user  = grant;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start)     state_d = ST_RUN;
      ST_RUN:   if (stop)      state_d = ST_DRAIN;
      ST_DRAIN: if (slot_free) state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_OUT_PORTS; i++)
      eligible[i] = vld_user[i] && entry_valid_q[i] && (credit_q[i] != '0);
  end

  // Two passes give the rotation: ports at/after ptr first, then the wrapped-around ones.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++)
      if (grant_en && !found && eligible[i] && (i >= int'(ptr_q))) begin
        found = 1'b1;
        gidx  = SEL_BITS'(i);
      end
    for (int i = 0; i < NUM_OUT_PORTS; i++)
      if (grant_en && !found && eligible[i] && (i < int'(ptr_q))) begin
        found = 1'b1;
        gidx  = SEL_BITS'(i);
      end

    grant       = '0;
    sel_payload = '0;
    sel_leaf    = '0;
    sel_dport   = '0;
    sel_addr    = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++)
      if (found && (gidx == SEL_BITS'(i))) begin
        grant[i]    = 1'b1;
        sel_payload = din_user[i*PAYLOAD_BITS +: PAYLOAD_BITS];
        sel_leaf    = leaf_q[i];
        sel_dport   = dport_q[i];
        sel_addr    = addr_q[i];
      end

    ptr_d = ptr_q;
    if (found)
      ptr_d = (gidx == SEL_BITS'(NUM_OUT_PORTS - 1)) ? '0 : gidx + 1'b1;
  end

  // One extra bit of headroom so the saturation compare sees the true sum.
  always_comb begin
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      cred_sum[i] = {1'b0, credit_q[i]} - {{CRED_BITS{1'b0}}, grant[i]}
                    + (credit_upd[i] ? CRED_UPD : '0);
      credit_d[i] = (cred_sum[i] > CRED_MAX_X) ? CRED_MAX : cred_sum[i][CRED_BITS-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      pkt_vld       <= 1'b0;
      pkt_out       <= '0;
      entry_valid_q <= '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        leaf_q[i]   <= '0;
        dport_q[i]  <= '0;
        addr_q[i]   <= '0;
        credit_q[i] <= CRED_MAX;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (found) begin
        pkt_out <= {1'b1, sel_leaf, sel_dport, sel_addr, sel_payload};
        pkt_vld <= 1'b1;
      end else if (pkt_ack) begin
        pkt_vld <= 1'b0;
      end
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credit_q[i] <= credit_d[i];
        if (cfg_wr_en && (cfg_sel == SEL_BITS'(i))) begin
          entry_valid_q[i] <= 1'b1;
          leaf_q[i]        <= cfg_leaf;
          dport_q[i]       <= cfg_dport;
          addr_q[i]        <= '0;
        end else if (grant[i]) begin
          addr_q[i] <= addr_q[i] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// tb_leaf_out_arbiter: cycle model of the arbiter with a queue of expected packets;
// grants, handshake and packet contents are compared every cycle.
module tb_leaf_out_arbiter;
  localparam int N = 3, PB = 32, LB = 5, DB = 4, AB = 7, UPD = 64, PKB = 49, SB = 2;
  localparam int DEPTH = 128;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;

  logic            clk = 1'b0;
  logic            reset, start, stop, busy, cfg_wr_en;
  logic [SB-1:0]   cfg_sel;
  logic [LB-1:0]   cfg_leaf;
  logic [DB-1:0]   cfg_dport;
  logic [N*PB-1:0] din_user;
  logic [N-1:0]    vld_user, ack_user, credit_upd;
  logic [PKB-1:0]  pkt_out;
  logic            pkt_vld, pkt_ack;

  int n_tests = 0, n_fail = 0;

  int              m_state, m_ptr;
  bit              m_vld;
  bit              m_valid  [N];
  logic [LB-1:0]   m_leaf   [N];
  logic [DB-1:0]   m_dport  [N];
  int              m_addr   [N];
  int              m_credit [N];
  logic [PKB-1:0]  exp_q [$];
  int              ack_cnt [N];
  logic [PKB-1:0]  held, exp_first;

  leaf_out_arbiter dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .busy(busy),
    .cfg_wr_en(cfg_wr_en), .cfg_sel(cfg_sel), .cfg_leaf(cfg_leaf), .cfg_dport(cfg_dport),
    .din_user(din_user), .vld_user(vld_user), .ack_user(ack_user), .credit_upd(credit_upd),
    .pkt_out(pkt_out), .pkt_vld(pkt_vld), .pkt_ack(pkt_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE;
    m_ptr   = 0;
    m_vld   = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_valid[i]  = 1'b0;
      m_leaf[i]   = '0;
      m_dport[i]  = '0;
      m_addr[i]   = 0;
      m_credit[i] = DEPTH;
    end
    exp_q.delete();
  endtask

  task automatic clear_cnt();
    for (int i = 0; i < N; i++) ack_cnt[i] = 0;
  endtask

  // Check at the falling edge, advance the model to the next rising edge, then clear pulses.
  task automatic step();
    int             g;
    bit             free, old_vld;
    logic [N-1:0]   exp_ack;
    logic [PB-1:0]  pay;
    @(negedge clk);
    g    = -1;
    free = !m_vld || pkt_ack;
    if (m_state == M_RUN && free)
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (g < 0 && vld_user[j] && m_valid[j] && m_credit[j] != 0) g = j;
      end
    exp_ack = '0;
    if (g >= 0) exp_ack[g] = 1'b1;
    chk("ack_user", 64'(ack_user), 64'(exp_ack));
    chk("pkt_vld", 64'(pkt_vld), 64'(m_vld));
    chk("busy", 64'(busy), 64'(m_state != M_IDLE));
    if (m_vld) begin
      chk("pkt_out", 64'(pkt_out), 64'(exp_q[0]));
      if (pkt_ack) void'(exp_q.pop_front());
    end
    for (int i = 0; i < N; i++) ack_cnt[i] += int'(ack_user[i]);

    old_vld = m_vld;
    if (g >= 0) begin
      pay = din_user[g*PB +: PB];
      exp_q.push_back({1'b1, m_leaf[g], m_dport[g], AB'(m_addr[g]), pay});
      m_ptr = (g + 1) % N;
      m_vld = 1'b1;
    end else if (pkt_ack) begin
      m_vld = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      m_credit[i] = m_credit[i] - ((g == i) ? 1 : 0) + (credit_upd[i] ? UPD : 0);
      if (m_credit[i] > DEPTH) m_credit[i] = DEPTH;
      if (cfg_wr_en && int'(cfg_sel) == i) begin
        m_valid[i] = 1'b1;
        m_leaf[i]  = cfg_leaf;
        m_dport[i] = cfg_dport;
        m_addr[i]  = 0;
      end else if (g == i) begin
        m_addr[i] = (m_addr[i] + 1) % DEPTH;
      end
    end
    case (m_state)
      M_IDLE:  if (start) m_state = M_RUN;
      M_RUN:   if (stop) m_state = M_DRAIN;
      default: if (!old_vld || pkt_ack) m_state = M_IDLE;
    endcase

    @(posedge clk);
    #1;
    start      = 1'b0;
    stop       = 1'b0;
    cfg_wr_en  = 1'b0;
    credit_upd = '0;
    for (int i = 0; i < N; i++) din_user[i*PB +: PB] = $urandom();
  endtask

  task automatic cfg(input int sel, input int leaf, input int dport);
    cfg_wr_en = 1'b1;
    cfg_sel   = SB'(sel);
    cfg_leaf  = LB'(leaf);
    cfg_dport = DB'(dport);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; cfg_wr_en = 1'b0;
    cfg_sel = '0; cfg_leaf = '0; cfg_dport = '0;
    din_user = '0; vld_user = '0; credit_upd = '0; pkt_ack = 1'b0;
    model_reset();
    clear_cnt();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pkt_vld", 64'(pkt_vld), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ack", 64'(ack_user), 64'd0);
    chk("rst_pkt_out", 64'(pkt_out), 64'd0);
    reset = 1'b0;

    // first packet and address stamping
    cfg(0, 5, 2);
    step();
    start = 1'b1;
    step();
    vld_user = 3'b001;
    pkt_ack  = 1'b1;
    din_user[31:0] = 32'hA5A5A5A5;
    step();
    exp_first = {1'b1, 5'd5, 4'd2, 7'd0, 32'hA5A5A5A5};
    chk("first_pkt", 64'(pkt_out), 64'(exp_first));
    step();
    chk("second_addr", 64'(pkt_out[38:32]), 64'd1);

    // round robin over all ports, with a cfg rewrite colliding with an accept on port 0
    vld_user = '0;
    cfg(1, 9, 3);
    step();
    cfg(2, 17, 7);
    step();
    vld_user = 3'b111;
    clear_cnt();
    for (int k = 0; k < 9; k++) begin
      if (k == 2) cfg(0, 6, 4);
      step();
    end
    chk("rr_total", 64'(ack_cnt[0] + ack_cnt[1] + ack_cnt[2]), 64'd9);
    chk("rr_port1", 64'(ack_cnt[1]), 64'd3);

    // credit exhaustion and refill on port 1, with saturation and address wrap
    vld_user   = '0;
    credit_upd = 3'b010;
    step();
    cfg(1, 9, 3);
    step();
    vld_user = 3'b010;
    clear_cnt();
    repeat (130) step();
    chk("credit_stall", 64'(ack_cnt[1]), 64'd128);
    credit_upd = 3'b010;
    step();
    clear_cnt();
    repeat (70) step();
    chk("credit_refill", 64'(ack_cnt[1]), 64'd64);

    // backpressure hold, then same-cycle drain and refill
    vld_user = 3'b001;
    pkt_ack  = 1'b0;
    step();
    held = pkt_out;
    clear_cnt();
    repeat (5) begin
      step();
      chk("hold_stable", 64'(pkt_out), 64'(held));
    end
    chk("hold_no_ack", 64'(ack_cnt[0]), 64'd0);
    pkt_ack = 1'b1;
    step();
    chk("refill_ack", 64'(ack_cnt[0]), 64'd1);

    // stop with a packet pending
    pkt_ack = 1'b0;
    stop    = 1'b1;
    step();
    repeat (3) step();
    chk("drain_busy", 64'(busy), 64'd1);
    pkt_ack = 1'b1;
    step();
    chk("drain_idle", 64'(busy), 64'd0);
    vld_user = 3'b111;
    clear_cnt();
    repeat (3) step();
    chk("idle_no_grant", 64'(ack_cnt[0] + ack_cnt[1] + ack_cnt[2]), 64'd0);

    // stop coinciding with a grant
    start = 1'b1;
    step();
    stop = 1'b1;
    step();
    repeat (3) step();
    chk("stop_grant", 64'(ack_cnt[0] + ack_cnt[1] + ack_cnt[2]), 64'd1);

    // reset mid-stream
    start = 1'b1;
    step();
    repeat (3) step();
    reset = 1'b1;
    #1;
    chk("rst_async_vld", 64'(pkt_vld), 64'd0);
    chk("rst_async_ack", 64'(ack_user), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    vld_user = 3'b100;
    cfg(2, 3, 1);
    step();
    start = 1'b1;
    step();
    clear_cnt();
    repeat (132) step();
    chk("post_rst_credit", 64'(ack_cnt[2]), 64'd128);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
